// File: rtl/async_receiver.sv
// 8N1 UART receiver: oversampling tick divider, two-flop synchronizer with a
// 3-tap majority filter, and a mid-bit sampling state machine.
module async_receiver #(
  parameter int unsigned ClkFrequency = 50000000,
  parameter int unsigned Baud         = 115200,
  parameter int unsigned Oversampling = 8
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       UART_RXD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       rx_idle,
  output logic       LEDG
);

  localparam int unsigned Div  = ClkFrequency / (Baud * Oversampling);
  localparam int unsigned DivW = $clog2(Div);
  localparam int unsigned OsW  = $clog2(Oversampling);

  localparam logic [DivW-1:0] DivLast  = DivW'(Div - 1);
  localparam logic [OsW-1:0]  OsLast   = OsW'(Oversampling - 1);
  localparam logic [OsW-1:0]  HalfLast = OsW'(Oversampling / 2 - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  logic [DivW-1:0] divCnt;
  logic            tick;
  logic            rxMeta, rxSync;
  logic [2:0]      rxHist;
  logic            rxs;
  state_e          state;
  logic [OsW-1:0]  sampleCnt;
  logic [2:0]      bitIdx;
  logic [7:0]      shiftReg;

  assign tick = (divCnt == DivLast);

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      divCnt <= '0;
    end else if (tick) begin
      divCnt <= '0;
    end else begin
      divCnt <= divCnt + 1'b1;
    end
  end

  // Synchronizer and filter reset high so the line reads idle out of reset.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      rxHist <= 3'b111;
    end else begin
      rxMeta <= UART_RXD;
      rxSync <= rxMeta;
      if (tick) begin
        rxHist <= {rxHist[1:0], rxSync};
      end
    end
  end

  assign rxs = (rxHist[0] & rxHist[1]) | (rxHist[0] & rxHist[2]) | (rxHist[1] & rxHist[2]);

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      sampleCnt   <= '0;
      bitIdx      <= '0;
      shiftReg    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      rx_idle     <= 1'b1;
    end else begin
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      rx_idle     <= (state == StIdle);
      if (tick) begin
        case (state)
          StIdle: begin
            if (!rxs) begin
              sampleCnt <= '0;
              state     <= StStart;
            end
          end
          StStart: begin
            if (sampleCnt == HalfLast) begin
              if (rxs) begin
                state <= StIdle;
              end else begin
                sampleCnt <= '0;
                bitIdx    <= '0;
                state     <= StData;
              end
            end else begin
              sampleCnt <= sampleCnt + 1'b1;
            end
          end
          StData: begin
            if (sampleCnt == OsLast) begin
              shiftReg  <= {rxs, shiftReg[7:1]};
              sampleCnt <= '0;
              if (bitIdx == 3'd7) begin
                state <= StStop;
              end else begin
                bitIdx <= bitIdx + 1'b1;
              end
            end else begin
              sampleCnt <= sampleCnt + 1'b1;
            end
          end
          StStop: begin
            if (sampleCnt == OsLast) begin
              sampleCnt <= '0;
              if (rxs) begin
                rx_data  <= shiftReg;
                rx_valid <= 1'b1;
                state    <= StIdle;
              end else begin
                frame_error <= 1'b1;
                state       <= StBreak;
              end
            end else begin
              sampleCnt <= sampleCnt + 1'b1;
            end
          end
          StBreak: begin
            // A held-low line yields one frame_error; wait for it to release.
            if (rxs) begin
              state <= StIdle;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

  assign LEDG = ~rx_idle;

endmodule

// File: tb/tb_async_receiver.sv
// Self-checking bench for async_receiver: directed scenarios plus random bytes,
// scored against a queue of bytes the bench itself transmitted.
`timescale 1ns/1ps
module tb_async_receiver;

  localparam int BitNs = 160;  // 16 clocks of 10 ns

  logic       CLOCK_50 = 1'b0;
  logic       rst      = 1'b1;
  logic       UART_RXD = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       rx_idle;
  logic       LEDG;

  async_receiver #(
    .ClkFrequency(1600000),
    .Baud        (100000),
    .Oversampling(8)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .rst        (rst),
    .UART_RXD   (UART_RXD),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_error(frame_error),
    .rx_idle    (rx_idle),
    .LEDG       (LEDG)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int         testsRun = 0;
  int         testsFailed = 0;
  int         validCnt = 0;
  int         feCnt = 0;
  int         unexpectedCnt = 0;
  int         cycle = 0;
  logic [7:0] expQ[$];
  int         validAt[$];
  logic [7:0] expByte;
  logic [7:0] lastGood = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every rx_valid must deliver the oldest byte still owed.
  always @(negedge CLOCK_50) begin
    cycle++;
    if (rst == 1'b0) begin
      if (rx_valid) begin
        validCnt++;
        validAt.push_back(cycle);
        if (expQ.size() > 0) begin
          expByte = expQ.pop_front();
          check("rx_data_order", {24'h0, rx_data}, {24'h0, expByte});
        end else begin
          unexpectedCnt++;
        end
      end
      if (frame_error) feCnt++;
    end
  end

  task automatic sendFrame(input logic [7:0] data, input logic stopBit, input int bitNs);
    UART_RXD = 1'b0;
    #(bitNs);
    for (int i = 0; i < 8; i++) begin
      UART_RXD = data[i];
      #(bitNs);
    end
    UART_RXD = stopBit;
    #(bitNs);
  endtask

  task automatic sendGood(input logic [7:0] data, input int bitNs);
    expQ.push_back(data);
    lastGood = data;
    sendFrame(data, 1'b1, bitNs);
  endtask

  task automatic settle();
    #(4 * BitNs);
    @(negedge CLOCK_50);
  endtask

  int         v0, f0, a0, d;
  logic [7:0] prev;
  logic [7:0] rb;
  int         rates[2] = '{155, 165};

  initial begin
    repeat (3) @(negedge CLOCK_50);
    check("reset_rx_data", {24'h0, rx_data}, 32'h0);
    check("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("reset_frame_error", {31'h0, frame_error}, 32'h0);
    check("reset_rx_idle", {31'h0, rx_idle}, 32'h1);
    check("reset_ledg", {31'h0, LEDG}, 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge CLOCK_50);

    // Single byte
    v0 = validCnt; f0 = feCnt;
    sendGood(8'hA5, BitNs);
    settle();
    check("single_valid_count", validCnt - v0, 1);
    check("single_data", {24'h0, rx_data}, 32'hA5);
    check("single_no_fe", feCnt - f0, 0);
    check("single_idle", {31'h0, rx_idle}, 32'h1);
    check("single_ledg", {31'h0, LEDG}, 32'h0);

    // Back-to-back, no idle gap
    v0 = validCnt; a0 = validAt.size();
    sendGood(8'h00, BitNs);
    sendGood(8'hFF, BitNs);
    sendGood(8'h3C, BitNs);
    settle();
    check("b2b_valid_count", validCnt - v0, 3);
    check("b2b_drained", expQ.size(), 0);
    if (validAt.size() >= a0 + 3) begin
      for (int i = 1; i < 3; i++) begin
        d = validAt[a0 + i] - validAt[a0 + i - 1];
        check("b2b_spacing", {31'h0, (d >= 158 && d <= 162)}, 32'h1);
      end
    end

    // Short glitch
    v0 = validCnt; f0 = feCnt;
    UART_RXD = 1'b0;
    #30;
    UART_RXD = 1'b1;
    #160;
    @(negedge CLOCK_50);
    check("glitch_idle", {31'h0, rx_idle}, 32'h1);
    #(2 * BitNs);
    check("glitch_no_valid", validCnt - v0, 0);
    check("glitch_no_fe", feCnt - f0, 0);

    // Framing error followed by a held-low line
    v0 = validCnt; f0 = feCnt; prev = lastGood;
    sendFrame(8'h5A, 1'b0, BitNs);
    #400;
    UART_RXD = 1'b1;
    settle();
    check("fe_count", feCnt - f0, 1);
    check("fe_no_valid", validCnt - v0, 0);
    check("fe_data_held", {24'h0, rx_data}, {24'h0, prev});
    v0 = validCnt;
    sendGood(8'h81, BitNs);
    settle();
    check("after_fe_valid", validCnt - v0, 1);
    check("after_fe_data", {24'h0, rx_data}, 32'h81);

    // Reset during bit 3, held until the partial frame has left the line
    v0 = validCnt; f0 = feCnt;
    fork
      sendFrame(8'hC3, 1'b1, BitNs);
      begin
        #(4 * BitNs + 80);
        @(negedge CLOCK_50);
        check("pre_rst_busy", {31'h0, LEDG}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_rx_data", {24'h0, rx_data}, 32'h0);
        check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("rst_frame_error", {31'h0, frame_error}, 32'h0);
        check("rst_rx_idle", {31'h0, rx_idle}, 32'h1);
        check("rst_ledg", {31'h0, LEDG}, 32'h0);
      end
    join
    #(BitNs);
    @(negedge CLOCK_50);
    rst = 1'b0;
    #(2 * BitNs);
    check("rst_no_valid", validCnt - v0, 0);
    check("rst_no_fe", feCnt - f0, 0);
    sendGood(8'h7E, BitNs);
    settle();
    check("after_rst_valid", validCnt - v0, 1);
    check("after_rst_data", {24'h0, rx_data}, 32'h7E);

    // Bit period skewed ~3% each way
    foreach (rates[r]) begin
      v0 = validCnt; f0 = feCnt;
      sendGood(8'h55, rates[r]);
      settle();
      check("rate_valid", validCnt - v0, 1);
      check("rate_data", {24'h0, rx_data}, 32'h55);
      check("rate_no_fe", feCnt - f0, 0);
    end

    // Random bytes with random (possibly zero) idle gaps
    v0 = validCnt; f0 = feCnt;
    for (int n = 0; n < 16; n++) begin
      rb = 8'($urandom_range(0, 255));
      sendGood(rb, BitNs);
      #($urandom_range(0, 300));
    end
    settle();
    check("rand_valid_count", validCnt - v0, 16);
    check("rand_drained", expQ.size(), 0);
    check("rand_no_fe", feCnt - f0, 0);
    check("rand_last_data", {24'h0, rx_data}, {24'h0, lastGood});
    check("no_unexpected_valid", unexpectedCnt, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", testsRun);
    $fatal(1);
  end

endmodule
